// File: rtl/maze_solve.sv
// Wall-following maze solver: sequences forward moves and heading changes for
// the navigator, choosing each new direction from the IR openings and wall affinity.
module maze_solve #(
  parameter logic [11:0] INIT_HDNG  = 12'h000,
  parameter int          SETTLE_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        solve_en,
  input  logic        lft_afnty,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        frwrd_opn,
  input  logic        mv_cmplt,
  input  logic        sol_cmplt,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  output logic        solved,
  output logic [7:0]  mv_cnt
);

  localparam logic [11:0] HDG_N = 12'h000;
  localparam logic [11:0] HDG_W = 12'h3FF;
  localparam logic [11:0] HDG_S = 12'h7FF;
  localparam logic [11:0] HDG_E = 12'hC00;
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_MV,
    WAIT_MV,
    SETTLE,
    DECIDE,
    WAIT_HDNG,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        aff_q, aff_d;
  logic [7:0]  settle_q, settle_d;
  logic        strt_hdng_q, strt_hdng_d;
  logic        strt_mv_q, strt_mv_d;
  logic        stp_lft_q, stp_lft_d;
  logic        stp_rght_q, stp_rght_d;
  logic [11:0] hdng_q, hdng_d;
  logic        solved_q, solved_d;
  logic [7:0]  mv_cnt_q, mv_cnt_d;
  logic        do_turn;

  // Headings are rotated by table lookup so the value can never leave the legal set.
  function automatic logic [11:0] turn_left(input logic [11:0] h);
    case (h)
      HDG_N:   return HDG_W;
      HDG_W:   return HDG_S;
      HDG_S:   return HDG_E;
      default: return HDG_N;
    endcase
  endfunction

  function automatic logic [11:0] turn_right(input logic [11:0] h);
    case (h)
      HDG_N:   return HDG_E;
      HDG_E:   return HDG_S;
      HDG_S:   return HDG_W;
      default: return HDG_N;
    endcase
  endfunction

  function automatic logic [11:0] turn_back(input logic [11:0] h);
    case (h)
      HDG_N:   return HDG_S;
      HDG_S:   return HDG_N;
      HDG_W:   return HDG_E;
      default: return HDG_W;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    aff_d       = aff_q;
    settle_d    = settle_q;
    strt_hdng_d = 1'b0;
    strt_mv_d   = 1'b0;
    stp_lft_d   = stp_lft_q;
    stp_rght_d  = stp_rght_q;
    hdng_d      = hdng_q;
    solved_d    = solved_q;
    mv_cnt_d    = mv_cnt_q;
    do_turn     = 1'b0;

    if (!solve_en) begin
      state_d    = IDLE;
      stp_lft_d  = 1'b0;
      stp_rght_d = 1'b0;
      solved_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          aff_d   = lft_afnty;
          state_d = ISSUE_MV;
        end
        ISSUE_MV: begin
          strt_mv_d  = 1'b1;
          stp_lft_d  = aff_q;
          stp_rght_d = ~aff_q;
          if (mv_cnt_q != 8'hFF) mv_cnt_d = mv_cnt_q + 8'd1;
          state_d = WAIT_MV;
        end
        // A completion coinciding with our own start pulse belongs to the previous command.
        WAIT_MV: begin
          if (mv_cmplt && !strt_mv_q) begin
            if (sol_cmplt) begin
              solved_d = 1'b1;
              state_d  = DONE;
            end else begin
              settle_d = SETTLE_LOAD;
              state_d  = SETTLE;
            end
          end
        end
        SETTLE: begin
          if (settle_q == 8'd0) state_d = DECIDE;
          else settle_d = settle_q - 8'd1;
        end
        DECIDE: begin
          do_turn = 1'b1;
          if (aff_q) begin
            if (lft_opn)        hdng_d = turn_left(hdng_q);
            else if (frwrd_opn) do_turn = 1'b0;
            else if (rght_opn)  hdng_d = turn_right(hdng_q);
            else                hdng_d = turn_back(hdng_q);
          end else begin
            if (rght_opn)       hdng_d = turn_right(hdng_q);
            else if (frwrd_opn) do_turn = 1'b0;
            else if (lft_opn)   hdng_d = turn_left(hdng_q);
            else                hdng_d = turn_back(hdng_q);
          end
          strt_hdng_d = do_turn;
          state_d     = do_turn ? WAIT_HDNG : ISSUE_MV;
        end
        WAIT_HDNG: begin
          if (mv_cmplt && !strt_hdng_q) state_d = ISSUE_MV;
        end
        DONE: begin
          solved_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aff_q       <= 1'b0;
      settle_q    <= 8'd0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      hdng_q      <= INIT_HDNG;
      solved_q    <= 1'b0;
      mv_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      aff_q       <= aff_d;
      settle_q    <= settle_d;
      strt_hdng_q <= strt_hdng_d;
      strt_mv_q   <= strt_mv_d;
      stp_lft_q   <= stp_lft_d;
      stp_rght_q  <= stp_rght_d;
      hdng_q      <= hdng_d;
      solved_q    <= solved_d;
      mv_cnt_q    <= mv_cnt_d;
    end
  end

  assign strt_hdng = strt_hdng_q;
  assign strt_mv   = strt_mv_q;
  assign stp_lft   = stp_lft_q;
  assign stp_rght  = stp_rght_q;
  assign dsrd_hdng = hdng_q;
  assign solved    = solved_q;
  assign mv_cnt    = mv_cnt_q;

endmodule

// File: tb/tb_maze_solve.sv
// Self-checking bench for maze_solve: plays the navigator role and predicts
// headings, pulses and move counts with a compass-index reference model.
module tb_maze_solve;

  localparam int SETTLE_CYC = 8;

  logic        clk, rst_n, solve_en, lft_afnty;
  logic        lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght, solved;
  logic [11:0] dsrd_hdng;
  logic [7:0]  mv_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: heading as compass index N=0, W=1, S=2, E=3 (counter-clockwise).
  logic [11:0] hdg_tab [4] = '{12'h000, 12'h3FF, 12'h7FF, 12'hC00};
  int   hdng_m   = 0;
  int   mv_cnt_m = 0;
  logic aff_m    = 1'b0;

  maze_solve #(.INIT_HDNG(12'h000), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .solve_en(solve_en), .lft_afnty(lft_afnty),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
    .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt), .strt_hdng(strt_hdng),
    .strt_mv(strt_mv), .stp_lft(stp_lft), .stp_rght(stp_rght),
    .dsrd_hdng(dsrd_hdng), .solved(solved), .mv_cnt(mv_cnt)
  );

  always #10 clk = ~clk;

  // Pulse-shape and heading-legality invariants checked every cycle.
  logic prev_h = 1'b0, prev_m = 1'b0;
  always @(negedge clk) begin
    n_cmp++;
    if (strt_hdng === 1'b1 && strt_mv === 1'b1) begin
      n_fail++; $display("[TB] FAIL pulse_overlap: got both pulses high, required at most one");
    end
    n_cmp++;
    if ((strt_hdng === 1'b1 && prev_h === 1'b1) || (strt_mv === 1'b1 && prev_m === 1'b1)) begin
      n_fail++; $display("[TB] FAIL pulse_width: got pulse high two clks, required one");
    end
    n_cmp++;
    if (!(dsrd_hdng inside {12'h000, 12'h3FF, 12'h7FF, 12'hC00})) begin
      n_fail++; $display("[TB] FAIL hdng_legal: got %h, required a legal heading", dsrd_hdng);
    end
    prev_h = strt_hdng;
    prev_m = strt_mv;
  end

  function automatic int turn_offset(input logic a, input logic l, input logic r, input logic f);
    if (a) begin
      if (l) return 1;
      if (f) return 0;
      if (r) return 3;
      return 2;
    end else begin
      if (r) return 3;
      if (f) return 0;
      if (l) return 1;
      return 2;
    end
  endfunction

  task automatic wait_pulse(input int limit, output int k, output logic gh, output logic gm);
    k = 0; gh = 1'b0; gm = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (strt_hdng === 1'b1 || strt_mv === 1'b1) begin
        k = i; gh = strt_hdng; gm = strt_mv;
        break;
      end
    end
  endtask

  task automatic bump_cnt();
    if (mv_cnt_m < 255) mv_cnt_m++;
  endtask

  task automatic start_solve(input logic a);
    int k; logic gh, gm;
    solve_en = 1'b0;
    @(negedge clk); @(negedge clk);
    lft_afnty = a; aff_m = a; solve_en = 1'b1;
    wait_pulse(2, k, gh, gm);
    bump_cnt();
    n_cmp++;
    if (!(gm === 1'b1 && gh === 1'b0)) begin
      n_fail++; $display("[TB] FAIL start_mv: got strt_mv=%b strt_hdng=%b, required 1/0 within 2 clks", gm, gh);
    end
    n_cmp++;
    if (stp_lft !== a || stp_rght !== ~a) begin
      n_fail++; $display("[TB] FAIL start_stp: got %b%b, required %b%b", stp_lft, stp_rght, a, ~a);
    end
    n_cmp++;
    if (mv_cnt !== 8'(mv_cnt_m)) begin
      n_fail++; $display("[TB] FAIL start_cnt: got %0d, required %0d", mv_cnt, mv_cnt_m);
    end
    n_cmp++;
    if (dsrd_hdng !== hdg_tab[hdng_m]) begin
      n_fail++; $display("[TB] FAIL start_hdng: got %h, required %h", dsrd_hdng, hdg_tab[hdng_m]);
    end
    @(negedge clk);
  endtask

  // One move completion from WAIT_MV through the next strt_mv, checked against the model.
  task automatic step(input logic l, input logic r, input logic f);
    int k, t; logic gh, gm;
    t = turn_offset(aff_m, l, r, f);
    lft_opn = l; rght_opn = r; frwrd_opn = f;
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    wait_pulse(SETTLE_CYC + 6, k, gh, gm);
    if (t != 0) begin
      hdng_m = (hdng_m + t) % 4;
      n_cmp++;
      if (!(gh === 1'b1 && gm === 1'b0 && k == SETTLE_CYC + 1)) begin
        n_fail++; $display("[TB] FAIL turn_pulse: got hdng=%b mv=%b at clk %0d, required 1/0 at %0d", gh, gm, k, SETTLE_CYC + 1);
      end
      n_cmp++;
      if (dsrd_hdng !== hdg_tab[hdng_m]) begin
        n_fail++; $display("[TB] FAIL turn_hdng: got %h, required %h", dsrd_hdng, hdg_tab[hdng_m]);
      end
      @(negedge clk);
      mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
      wait_pulse(4, k, gh, gm);
    end else begin
      n_cmp++;
      if (k != SETTLE_CYC + 2) begin
        n_fail++; $display("[TB] FAIL straight_lat: got clk %0d, required %0d", k, SETTLE_CYC + 2);
      end
    end
    bump_cnt();
    n_cmp++;
    if (!(gm === 1'b1 && gh === 1'b0)) begin
      n_fail++; $display("[TB] FAIL move_pulse: got mv=%b hdng=%b, required 1/0", gm, gh);
    end
    n_cmp++;
    if (dsrd_hdng !== hdg_tab[hdng_m] || mv_cnt !== 8'(mv_cnt_m)) begin
      n_fail++; $display("[TB] FAIL move_state: got hdng=%h cnt=%0d, required %h %0d", dsrd_hdng, mv_cnt, hdg_tab[hdng_m], mv_cnt_m);
    end
    n_cmp++;
    if (stp_lft !== aff_m || stp_rght !== ~aff_m) begin
      n_fail++; $display("[TB] FAIL move_stp: got %b%b, required %b%b", stp_lft, stp_rght, aff_m, ~aff_m);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #3;
    n_cmp++;
    if ({strt_hdng, strt_mv, stp_lft, stp_rght, solved} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b, required 00000", {strt_hdng, strt_mv, stp_lft, stp_rght, solved});
    end
    n_cmp++;
    if (dsrd_hdng !== 12'h000) begin
      n_fail++; $display("[TB] FAIL reset_hdng: got %h, required 000", dsrd_hdng);
    end
    n_cmp++;
    if (mv_cnt !== 8'd0) begin
      n_fail++; $display("[TB] FAIL reset_cnt: got %0d, required 0", mv_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    hdng_m = 0; mv_cnt_m = 0;
  endtask

  task automatic test_left_affinity();
    start_solve(1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_right_wrap();
    test_reset();
    start_solve(1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) start_solve(1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_ignore_during_pulse();
    int k, seen; logic gh, gm;
    lft_opn = 1'b1; rght_opn = 1'b0; frwrd_opn = 1'b0;
    hdng_m = (hdng_m + turn_offset(aff_m, 1'b1, 1'b0, 1'b0)) % 4;
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    wait_pulse(SETTLE_CYC + 6, k, gh, gm);
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    seen = 0;
    for (int i = 0; i < SETTLE_CYC + 4; i++) begin
      @(negedge clk);
      if (strt_mv === 1'b1 || strt_hdng === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("[TB] FAIL ignore_pulse: got %0d pulses, required 0", seen);
    end
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    wait_pulse(4, k, gh, gm);
    bump_cnt();
    n_cmp++;
    if (gm !== 1'b1 || mv_cnt !== 8'(mv_cnt_m) || dsrd_hdng !== hdg_tab[hdng_m]) begin
      n_fail++; $display("[TB] FAIL ignore_resume: got mv=%b cnt=%0d hdng=%h, required 1 %0d %h", gm, mv_cnt, dsrd_hdng, mv_cnt_m, hdg_tab[hdng_m]);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (mv_cnt !== 8'hFF) begin
      n_fail++; $display("[TB] FAIL saturate: got %h, required FF", mv_cnt);
    end
  endtask

  task automatic test_solved();
    int seen;
    sol_cmplt = 1'b1;
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    n_cmp++;
    if (solved !== 1'b1) begin
      n_fail++; $display("[TB] FAIL solved_set: got %b, required 1", solved);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      mv_cmplt = (i % 4 == 0);
      @(negedge clk);
      if (strt_mv === 1'b1 || strt_hdng === 1'b1) seen++;
    end
    mv_cmplt = 1'b0;
    n_cmp++;
    if (seen != 0 || solved !== 1'b1) begin
      n_fail++; $display("[TB] FAIL solved_hold: got pulses=%0d solved=%b, required 0 1", seen, solved);
    end
    solve_en = 1'b0; sol_cmplt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (solved !== 1'b0 || stp_lft !== 1'b0 || stp_rght !== 1'b0) begin
      n_fail++; $display("[TB] FAIL solved_clear: got solved=%b stp=%b%b, required 0 00", solved, stp_lft, stp_rght);
    end
  endtask

  task automatic test_abort();
    int k, seen; logic gh, gm;
    start_solve(1'b1);
    step(1'b1, 1'b0, 1'b0);
    lft_opn = 1'b1; rght_opn = 1'b0; frwrd_opn = 1'b0;
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    @(negedge clk); @(negedge clk);
    solve_en = 1'b0;
    seen = 0;
    for (int i = 0; i < SETTLE_CYC + 4; i++) begin
      @(negedge clk);
      if (strt_mv === 1'b1 || strt_hdng === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0 || stp_lft !== 1'b0 || stp_rght !== 1'b0 || solved !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_settle: got pulses=%0d stp=%b%b solved=%b, required 0 00 0", seen, stp_lft, stp_rght, solved);
    end
    n_cmp++;
    if (dsrd_hdng !== hdg_tab[hdng_m] || mv_cnt !== 8'(mv_cnt_m)) begin
      n_fail++; $display("[TB] FAIL abort_retain: got %h %0d, required %h %0d", dsrd_hdng, mv_cnt, hdg_tab[hdng_m], mv_cnt_m);
    end
    start_solve(1'b0);
    lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
    hdng_m = (hdng_m + 2) % 4;
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    wait_pulse(SETTLE_CYC + 6, k, gh, gm);
    n_cmp++;
    if (gh !== 1'b1 || dsrd_hdng !== hdg_tab[hdng_m]) begin
      n_fail++; $display("[TB] FAIL abort_turn: got hdng pulse=%b hdng=%h, required 1 %h", gh, dsrd_hdng, hdg_tab[hdng_m]);
    end
    @(negedge clk);
    solve_en = 1'b0;
    @(negedge clk);
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (strt_mv === 1'b1 || strt_hdng === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0 || stp_lft !== 1'b0 || stp_rght !== 1'b0 || dsrd_hdng !== hdg_tab[hdng_m]) begin
      n_fail++; $display("[TB] FAIL abort_whdng: got pulses=%0d stp=%b%b hdng=%h, required 0 00 %h", seen, stp_lft, stp_rght, dsrd_hdng, hdg_tab[hdng_m]);
    end
    start_solve(1'b1);
    step(1'b1, 1'b0, 1'b0);
    mv_cmplt = 1'b1; @(negedge clk); mv_cmplt = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({strt_hdng, strt_mv, stp_lft, stp_rght, solved} !== 5'b0 || dsrd_hdng !== 12'h000 || mv_cnt !== 8'd0) begin
      n_fail++; $display("[TB] FAIL async_reset: got flags=%b hdng=%h cnt=%0d, required 00000 000 0", {strt_hdng, strt_mv, stp_lft, stp_rght, solved}, dsrd_hdng, mv_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; solve_en = 1'b0;
    hdng_m = 0; mv_cnt_m = 0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; solve_en = 1'b0; lft_afnty = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
    mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    $display("[TB] maze_solve bench starting");
    test_reset();
    test_left_affinity();
    test_right_wrap();
    test_random();
    test_ignore_during_pulse();
    test_saturation();
    test_solved();
    test_abort();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
